// File: rtl/wb_grf.sv
// wb_grf: writeback stage with load extension, link/ALU select, and a 32x32 register file with write-before-read bypass.
// Define WB_GRF_TRACE_EN to print a line for every register write or misaligned load.
module wb_grf #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr_W,
  input  logic [4:0]       RD_W,
  input  logic [31:0]      PC_W,
  input  logic [31:0]      AO_W,
  input  logic [31:0]      DR_W,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [31:0]      RD1,
  output logic [31:0]      RD2,
  output logic [31:0]      WD_W,
  output logic             WE_W,
  output logic             align_err,
  output logic [CNT_W-1:0] retired
);
  logic [5:0]       w_op;
  logic             w_lw, w_lb, w_lbu, w_lh, w_lhu, w_load, w_link, w_mis;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ld;
  logic [31:0]      r_regs [32];
  logic [CNT_W-1:0] r_ret;
  logic             r_ae;
  logic             w_unused_reset_pc;

  assign w_op   = Instr_W[31:26];
  assign w_lw   = w_op == 6'b100011;
  assign w_lb   = w_op == 6'b100000;
  assign w_lbu  = w_op == 6'b100100;
  assign w_lh   = w_op == 6'b100001;
  assign w_lhu  = w_op == 6'b100101;
  assign w_load = w_lw | w_lb | w_lbu | w_lh | w_lhu;
  assign w_link = (w_op == 6'b000011) || (w_op == 6'b000000 && Instr_W[5:0] == 6'b001001);
  assign w_mis  = ((w_lh | w_lhu) & AO_W[0]) | (w_lw & (AO_W[1:0] != 2'b00));

  assign w_byte = DR_W[{AO_W[1:0], 3'b000} +: 8];
  assign w_half = AO_W[1] ? DR_W[31:16] : DR_W[15:0];
  assign w_ld   = w_lb  ? {{24{w_byte[7]}}, w_byte} :
                  w_lbu ? {24'b0, w_byte} :
                  w_lh  ? {{16{w_half[15]}}, w_half} :
                  w_lhu ? {16'b0, w_half} : DR_W;

  assign WD_W = w_load ? w_ld : w_link ? PC_W + 32'd8 : AO_W;
  // Gating with reset keeps the bypass from leaking a write that reset will discard.
  assign WE_W = reset && (RD_W != 5'd0) && !w_mis;

  assign RD1 = (A1 == 5'd0) ? 32'd0 : (WE_W && A1 == RD_W) ? WD_W : r_regs[A1];
  assign RD2 = (A2 == 5'd0) ? 32'd0 : (WE_W && A2 == RD_W) ? WD_W : r_regs[A2];

  assign align_err = r_ae;
  assign retired   = r_ret;
  // Bubbles sit at RESET_PC with a zero instruction; the counter only needs the instruction.
  assign w_unused_reset_pc = ^RESET_PC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regs <= '{default: '0};
      r_ret  <= '0;
      r_ae   <= 1'b0;
    end else begin
      if (WE_W) r_regs[RD_W] <= WD_W;
      if (Instr_W != 32'd0) r_ret <= r_ret + CNT_W'(1);
      r_ae <= w_mis;
    end
  end

`ifdef WB_GRF_TRACE_EN
  always @(posedge clk) begin
    if (reset && WE_W) $display("@%08h: $%0d <= %08h", PC_W, RD_W, WD_W);
    else if (reset && w_mis) $display("@%08h: misaligned load", PC_W);
  end
`else
`endif
endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Writeback end of the MEM/WB pipeline register. Consumes the W-stage bundle (Instr_W, RD_W, PC_W, AO_W, DR_W).
- Forms the final write value: load extension, link address or ALU result.
- Owns the 32x32 general register file. Serves the two decode-stage read ports with internal write-before-read bypass.
- Keeps a retired-instruction counter for the bench.

Parameters:
- RESET_PC, 32'h0000_3000, PC value the W register holds after reset. Cycles with Instr_W==0 at this PC are bubbles.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock, all state updates on posedge
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low
- Instr_W  input  32  instruction in W stage
- RD_W  input  5  destination register; 0 means no write
- PC_W  input  32  PC of W-stage instruction
- AO_W  input  32  ALU result / memory address
- DR_W  input  32  raw aligned word read from data memory
- A1  input  5  decode read address 1
- A2  input  5  decode read address 2
- RD1  output  32  read data 1 (combinational)
- RD2  output  32  read data 2 (combinational)
- WD_W  output  32  value being written this cycle (for forwarding to E/M)
- WE_W  output  1  write actually performed this cycle
- align_err  output  1  registered; W-stage load was misaligned last cycle
- retired  output  CNT_W  count of non-bubble instructions that left W

Behaviour:
- Decode from Instr_W:
  - op=100011 lw; 100000 lb; 100100 lbu; 100001 lh; 100101 lhu → load.
  - op=000011 jal, or op=000000 with funct=001001 jalr → link.
  - Anything else → ALU.
- Load extension uses byte offset AO_W[1:0]:
  - lb / lbu: select byte DR_W[8*k+7:8*k] with k=AO_W[1:0]; sign- or zero-extend to 32 bits.
  - lh / lhu: select half DR_W[16*h+15:16*h] with h=AO_W[1]; sign- or zero-extend.
  - lw: DR_W unchanged.
- Misalignment:
  - lh/lhu with AO_W[0]=1, or lw with AO_W[1:0]!=0, is misaligned.
  - Misaligned load: WE_W=0 and no register write.
  - align_err goes to 1 on the next posedge and holds 1 cycle.
- WD_W selection: load → extended value; link → PC_W+8 (32-bit wrap); else → AO_W.
- WE_W = (RD_W!=0) && !misaligned. Register 0 is never written and always reads 0.
- Register file write: at posedge clk when WE_W, regs[RD_W] <= WD_W.
- Reads:
  - RD1 = (A1==0) ? 0 : (WE_W && A1==RD_W) ? WD_W : regs[A1]. RD2 is the same with A2.
  - The bypass makes a same-cycle W write visible to decode with zero latency.
- Retired counter:
  - Increments at posedge when Instr_W!=0, including misaligned loads.
  - Wraps from all-ones to 0 silently.
- Reset (reset==0, asynchronous):
  - All 32 registers, retired and align_err go to 0 immediately.
  - While low, no writes occur and RD1/RD2 read 0.
  - Writes resume on the first posedge after reset is released.
- Simultaneous events: reset low at a posedge with WE_W=1 → reset wins; the register stays 0.
- Latency:
  - Read → write visibility: 0 cycles through the bypass, 1 cycle through the array.
  - align_err: 1 cycle.

Optional Feature:
- Macro: WB_GRF_TRACE_EN.
- Defined: on every posedge with WE_W=1 and reset high, the simulator prints `@PC_W: $RD_W <= WD_W` (PC and data as 8-digit hex, register as decimal).
- Defined, misaligned load: prints `@PC_W: misaligned load` instead.
- Not defined: no display statements are compiled. Register-file behaviour is identical in both cases.

Test Plan:
- Reset: hold reset low 3 cycles, then issue any read → RD1=RD2=0, retired=0, align_err=0.
- ALU write: addu writing $8 with AO_W=32'h1234_5678, A1=8 in the same cycle → RD1=32'h1234_5678 via bypass. Next cycle, Instr_W=0 → RD1 still 32'h1234_5678 from the array.
- Byte/half loads with DR_W=32'h80FF_7F01 into $9:
  - lb, AO_W[1:0]=3 → $9=32'hFFFF_FF80.
  - lbu, AO_W[1:0]=3 → 32'h0000_0080.
  - lh, AO_W[1:0]=2 → 32'hFFFF_80FF.
  - lhu, AO_W[1:0]=0 → 32'h0000_7F01.
- Link: jal with PC_W=32'h0000_3010, RD_W=31 → $31=32'h0000_3018, WD_W=32'h0000_3018, WE_W=1.
- Boundaries:
  - lw with AO_W=32'h0000_0002 to $10 → WE_W=0, $10 unchanged, align_err=1 for exactly the next cycle, retired incremented.
  - Write with RD_W=0 and WD_W=32'hDEAD_BEEF → $0 reads 0.
- Reset mid-operation: reset low asynchronously between edges while $8 holds a nonzero value → RD1 for A1=8 becomes 0 before the next posedge. A write presented during reset is lost. retired=0 after release.
